// File: rtl/mm_iddmm_pkg.sv
// Shared types and helpers for the IDDMM compare-and-subtract stage.
// FSM encoding, task mode constants and the word-count clamp.
package mm_iddmm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P1       = 3'd1,
    P2       = 3'd2,
    DONE     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  localparam logic MODE_COND_SUB = 1'b0;
  localparam logic MODE_COPY     = 1'b1;

  // A zero or oversized request means "use the whole RAM".
  function automatic int eff_len(int len, int n);
    return (len <= 0 || len > n) ? n : len;
  endfunction

endpackage

// File: rtl/mm_iddmm_borrow_sub.sv
// One K-bit word of a borrow-chained subtraction: a - b - bin.
// Purely combinational; the parent registers the borrow.
module mm_iddmm_borrow_sub
  import mm_iddmm_pkg::*;
#(
  parameter int K = 128
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         bin,
  output logic [K-1:0] diff,
  output logic         bout
);

  logic [K:0] t;

  // Extra top bit catches the borrow out of the word.
  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - {{K{1'b0}}, bin};
    diff = t[K-1:0];
    bout = t[K];
  end

endmodule

// File: rtl/mm_iddmm_csub_rt.sv
// Runtime-length IDDMM final compare-and-subtract (A-M if A>=M else A).
// Define MM_IDDMM_CSUB_CLR_EN to zero the A RAM as it is consumed.
module mm_iddmm_csub_rt
  import mm_iddmm_pkg::*;
#(
  parameter int K = 128,
  parameter int N = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   task_req,
  input  logic [$clog2(N):0]     task_len,
  input  logic                   task_mode,
  output logic                   task_end,
  input  logic                   an,
  input  logic [K-1:0]           aj,
  input  logic [K-1:0]           mj,
  output logic [$clog2(N)-1:0]   addr_a,
  output logic [$clog2(N)-1:0]   addr_m,
  output logic [K-1:0]           res,
  output logic                   res_val,
  output logic                   res_last,
  output logic [$clog2(N)-1:0]   res_idx,
  output logic                   a_ge_m,
  output logic                   clra_mem,
  output logic                   clra_wren,
  output logic [$clog2(N)-1:0]   clra_addr
);

  localparam int AW = $clog2(N);

  state_t         state;
  logic           mode_q;
  logic           an_q;
  logic [AW-1:0]  len_m1;
  logic [AW-1:0]  cnt;
  logic           iss;
  logic           dv;
  logic [AW-1:0]  dv_idx;
  logic           brw;
  logic           ge_q;
  logic [K-1:0]   res_q;

  logic [K-1:0]   diff;
  logic           bout;
  logic           last;
  logic           use_sub;
  logic [K-1:0]   res_c;

  mm_iddmm_borrow_sub #(.K(K)) u_sub (
    .a    (aj),
    .b    (mj),
    .bin  (brw),
    .diff (diff),
    .bout (bout)
  );

  // Output word selection; res holds its last value between words.
  always_comb begin
    last     = dv && (dv_idx == len_m1);
    use_sub  = (mode_q == MODE_COND_SUB) && ge_q;
    res_c    = use_sub ? diff : aj;
    res_val  = dv && (state == P2);
    res      = res_val ? res_c : res_q;
    res_last = res_val && (dv_idx == len_m1);
    res_idx  = res_val ? dv_idx : '0;
    task_end = (state == DONE);
    a_ge_m   = ge_q;
    addr_a   = iss ? cnt : '0;
    addr_m   = (iss && mode_q == MODE_COND_SUB) ? cnt : '0;
  end

`ifdef MM_IDDMM_CSUB_CLR_EN
  // A RAM write port is owned for the whole task and zeroes consumed words.
  always_comb begin
    clra_mem  = (state == P1) || (state == P2) || (state == DONE);
    clra_wren = res_val;
    clra_addr = res_idx;
  end
`else
  // Clearing disabled: the A RAM write port is never taken.
  always_comb begin
    clra_mem  = 1'b0;
    clra_wren = 1'b0;
    clra_addr = '0;
  end
`endif

  // Address issue, read-data tracking, borrow chain and pass sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      an_q   <= 1'b0;
      len_m1 <= '0;
      cnt    <= '0;
      iss    <= 1'b0;
      dv     <= 1'b0;
      dv_idx <= '0;
      brw    <= 1'b0;
      ge_q   <= 1'b0;
      res_q  <= '0;
    end else begin
      dv <= iss;
      if (iss) begin
        dv_idx <= cnt;
        if (cnt == len_m1) iss <= 1'b0;
        else               cnt <= cnt + 1'b1;
      end
      if (res_val) res_q <= res_c;
      unique case (state)
        IDLE: begin
          if (task_req) begin
            mode_q <= task_mode;
            an_q   <= an;
            len_m1 <= AW'(eff_len(int'(task_len), N) - 1);
            iss    <= 1'b1;
            cnt    <= '0;
            brw    <= 1'b0;
            ge_q   <= 1'b0;
            state  <= (task_mode == MODE_COPY) ? P2 : P1;
          end
        end
        P1: begin
          if (dv) brw <= bout;
          if (last) begin
            ge_q  <= an_q | ~bout;
            brw   <= 1'b0;
            iss   <= 1'b1;
            cnt   <= '0;
            state <= P2;
          end
        end
        P2: begin
          if (dv && use_sub) brw <= bout;
          if (last) state <= DONE;
        end
        DONE:     state <= WAIT_LOW;
        WAIT_LOW: if (!task_req) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_iddmm_csub_rt.sv
// Self-checking bench for mm_iddmm_csub_rt (K=128, N=4).
// Big-number model predicts every result word, index and timing.
module tb_mm_iddmm_csub_rt;
  import mm_iddmm_pkg::*;

  localparam int K  = 128;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int LW = 3;
  localparam int BW = K * N + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          task_req = 1'b0;
  logic [LW-1:0] task_len = '0;
  logic          task_mode = 1'b0;
  logic          an = 1'b0;
  logic [K-1:0]  aj;
  logic [K-1:0]  mj;
  logic          task_end;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_m;
  logic [K-1:0]  res;
  logic          res_val;
  logic          res_last;
  logic [AW-1:0] res_idx;
  logic          a_ge_m;
  logic          clra_mem;
  logic          clra_wren;
  logic [AW-1:0] clra_addr;

  logic [K-1:0] a_img [N];
  logic [K-1:0] m_img [N];
  logic [K-1:0] ram_a [N];
  logic         ld = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  bit           act = 1'b0;
  bit           is_copy;
  int           t0, rs, te, exp_l;
  logic         exp_ge;
  logic [K-1:0] exp_res [N];
  logic [K-1:0] got_res [N];
  int           ck, ci;
  bit           ev;
  bit           an_r;

  mm_iddmm_csub_rt #(.K(K), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .task_req  (task_req),
    .task_len  (task_len),
    .task_mode (task_mode),
    .task_end  (task_end),
    .an        (an),
    .aj        (aj),
    .mj        (mj),
    .addr_a    (addr_a),
    .addr_m    (addr_m),
    .res       (res),
    .res_val   (res_val),
    .res_last  (res_last),
    .res_idx   (res_idx),
    .a_ge_m    (a_ge_m),
    .clra_mem  (clra_mem),
    .clra_wren (clra_wren),
    .clra_addr (clra_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    aj <= ram_a[addr_a];
    mj <= m_img[addr_m];
    if (ld) begin
      for (int i = 0; i < N; i++) ram_a[i] <= a_img[i];
    end else if (clra_wren) begin
      ram_a[clra_addr] <= '0;
    end
  end

  task automatic chk(input string nm, input logic [K-1:0] got,
                     input logic [K-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " res"}, res, '0);
    chk({tag, " res_val"}, K'(res_val), '0);
    chk({tag, " res_last"}, K'(res_last), '0);
    chk({tag, " res_idx"}, K'(res_idx), '0);
    chk({tag, " task_end"}, K'(task_end), '0);
    chk({tag, " a_ge_m"}, K'(a_ge_m), '0);
    chk({tag, " addr_a"}, K'(addr_a), '0);
    chk({tag, " addr_m"}, K'(addr_m), '0);
    chk({tag, " clra_mem"}, K'(clra_mem), '0);
    chk({tag, " clra_wren"}, K'(clra_wren), '0);
    chk({tag, " clra_addr"}, K'(clra_addr), '0);
  endtask

  // Compare process: timing windows come from cycle offsets after accept.
  always @(negedge clk) begin
    if (act) begin
      ck = cyc - t0;
      ev = (ck >= rs) && (ck < rs + exp_l);
      ci = ck - rs;
      chk("res_val", K'(res_val), K'(ev));
      if (ev) begin
        got_res[ci] = res;
        chk("res", res, exp_res[ci]);
        chk("res_idx", K'(res_idx), K'(ci));
        chk("res_last", K'(res_last), K'(ci == exp_l - 1));
`ifdef MM_IDDMM_CSUB_CLR_EN
        chk("clra_wren", K'(clra_wren), K'(1));
        chk("clra_addr", K'(clra_addr), K'(ci));
`endif
      end
      chk("task_end", K'(task_end), K'(ck == te));
      if (ck == te) chk("a_ge_m", K'(a_ge_m), K'(exp_ge));
      if (is_copy && ck > 0) chk("addr_m", K'(addr_m), '0);
`ifdef MM_IDDMM_CSUB_CLR_EN
      if (ck >= 1 && ck <= te) chk("clra_mem", K'(clra_mem), K'(1));
`endif
    end
  end

  task automatic load_a();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < N; i++) begin
      a_img[i] = '0;
      m_img[i] = '0;
    end
  endtask

  // Random M (L words, nonzero) and A < 2M, split into an and A words.
  task automatic gen_rand(input int l, output bit an_o);
    logic [575:0]  rr;
    logic [BW-1:0] mk, mv, av;
    mk = (BW'(1) << (K * l)) - BW'(1);
    for (int j = 0; j < 18; j++) rr[j*32 +: 32] = $urandom;
    mv = BW'(rr) & mk;
    if (mv == '0) mv = BW'(1);
    for (int j = 0; j < 18; j++) rr[j*32 +: 32] = $urandom;
    av = BW'(rr) % (mv << 1);
    an_o = av[K * l];
    clear_img();
    for (int i = 0; i < l; i++) begin
      a_img[i] = av[i*K +: K];
      m_img[i] = mv[i*K +: K];
    end
  endtask

  // Model the whole task as one big-number operation, then run it.
  task automatic run_task(input int len_in, input bit mode,
                          input bit an_in, input int stop_k);
    int            l;
    logic [BW-1:0] av, mv, rv;
    l = (len_in == 0 || len_in > N) ? N : len_in;
    av = '0;
    mv = '0;
    for (int i = 0; i < l; i++) begin
      av[i*K +: K] = a_img[i];
      mv[i*K +: K] = m_img[i];
    end
    av = av | (BW'(an_in) << (K * l));
    if (mode) begin
      exp_ge = 1'b0;
      rv = av;
    end else begin
      exp_ge = (av >= mv);
      rv = exp_ge ? av - mv : av;
    end
    for (int i = 0; i < N; i++) begin
      exp_res[i] = rv[i*K +: K];
      got_res[i] = 'x;
    end
    exp_l = l;
    is_copy = mode;
    rs = mode ? 2 : l + 3;
    te = mode ? l + 2 : 2 * l + 3;
    load_a();
    @(negedge clk);
    task_len = LW'(len_in);
    task_mode = mode;
    an = an_in;
    task_req = 1'b1;
    t0 = cyc;
    act = 1'b1;
    @(negedge clk);
    task_req = 1'b0;
    task_len = '0;
    an = 1'b0;
    if (stop_k > 0) begin
      repeat (stop_k - 1) @(negedge clk);
    end else begin
      repeat (te + 1) @(negedge clk);
    end
    act = 1'b0;
  endtask

  initial begin
    clear_img();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    clear_img();
    a_img[0] = 128'd5;
    m_img[0] = 128'd3;
    run_task(1, MODE_COND_SUB, 1'b0, 0);
    chk("t1 res0", got_res[0], 128'd2);
    chk("t1 a_ge_m", K'(a_ge_m), K'(1));

    clear_img();
    a_img[0] = 128'd3;
    m_img[0] = 128'd5;
    run_task(1, MODE_COND_SUB, 1'b0, 0);
    chk("t2 res0", got_res[0], 128'd3);
    chk("t2 a_ge_m", K'(a_ge_m), '0);

    clear_img();
    a_img[1] = 128'd1;
    m_img[0] = 128'd1;
    run_task(2, MODE_COND_SUB, 1'b0, 0);
    chk("t3 res0", got_res[0], {K{1'b1}});
    chk("t3 res1", got_res[1], '0);
    chk("t3 a_ge_m", K'(a_ge_m), K'(1));

    clear_img();
    m_img[1] = 128'd1;
    run_task(2, MODE_COND_SUB, 1'b1, 0);
    chk("t4 res0", got_res[0], '0);
    chk("t4 res1", got_res[1], {K{1'b1}});
    chk("t4 a_ge_m", K'(a_ge_m), K'(1));

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 4; j++) begin
        a_img[i][j*32 +: 32] = $urandom;
        m_img[i][j*32 +: 32] = $urandom;
      end
    end
    run_task(0, MODE_COPY, 1'b0, 0);
    for (int i = 0; i < N; i++) chk("t5 copy", got_res[i], a_img[i]);
    chk("t5 a_ge_m", K'(a_ge_m), '0);
`ifdef MM_IDDMM_CSUB_CLR_EN
    for (int i = 0; i < N; i++) chk("t5 cleared", ram_a[i], '0);
`endif

    gen_rand(4, an_r);
    run_task(7, MODE_COND_SUB, an_r, 0);

    gen_rand(4, an_r);
    run_task(4, MODE_COND_SUB, an_r, 8);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 100; n++) begin
      int l;
      l = $urandom_range(1, 4);
      gen_rand(l, an_r);
      run_task(l, (n % 7 == 6) ? MODE_COPY : MODE_COND_SUB, an_r, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mm_iddmm_csub_rt.md
Name: mm_iddmm_csub_rt

Overview:
- Runtime-configurable successor to the IDDMM final compare-and-subtract stage.
- Streams a multi-word operand A = {an, A[len-1:0]} and modulus M from external 1-cycle-latency RAMs.
- Emits A-M if A>=M, else A, one K-bit word per cycle, LSB first.
- Adds runtime word count, a copy/bypass mode, last-word/index tagging, a result-sign status flag, and optional A-memory clearing.

Parameters:
- K, 128, word width in bits.
- N, 32, maximum word count; RAM depth; power of 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- task_req  in  1  level request; sampled in IDLE.
- task_len  in  $clog2(N)+1  word count; 0 or >N treated as N; sampled at accept.
- task_mode  in  1  0 = COND_SUB, 1 = COPY; sampled at accept.
- task_end  out  1  one-cycle completion pulse.
- an  in  1  A top bit (weight 2^(K*len)); sampled at accept.
- aj  in  K  A RAM read data, valid 1 cycle after addr_a.
- mj  in  K  M RAM read data, valid 1 cycle after addr_m.
- addr_a  out  $clog2(N)  A RAM read address.
- addr_m  out  $clog2(N)  M RAM read address.
- res  out  K  result word.
- res_val  out  1  res valid.
- res_last  out  1  marks final result word.
- res_idx  out  $clog2(N)  word index of res.
- a_ge_m  out  1  compare outcome; valid from task_end until next accept.
- clra_mem  out  1  owns A RAM write port (mux select).
- clra_wren  out  1  A RAM write enable; data is all zeros.
- clra_addr  out  $clog2(N)  A RAM write address.

Behaviour:
- Reset: all outputs 0, borrow 0, state IDLE; applies immediately, including mid-task. No partial outputs after reset.
- FSM states:
  - IDLE -> P1 when task_req=1 and mode=COND_SUB.
  - IDLE -> P2 when task_req=1 and mode=COPY.
  - P1 -> P2 after the last P1 data word.
  - P2 -> DONE after the last result word.
  - DONE -> WAIT_LOW, task_end=1 for that cycle.
  - WAIT_LOW -> IDLE when task_req=0.
- task_req falling mid-task is ignored.
- Accept cycle is T0; L is the effective length.
- P1 (borrow pass, nothing emitted):
  - addr_a = addr_m = i at T0+1+i, for i = 0..L-1.
  - Data for word i is used at T0+2+i.
  - b_next = borrow of (aj - mj - b); b starts at 0.
  - Final borrow is registered at T0+L+1.
  - a_ge_m = an | ~b_final.
- P2 (output pass), base cycle S:
  - S = T0+L+2 for COND_SUB; S = T0+1 for COPY.
  - Addresses i issued at S+i.
  - res_val=1 at S+1+i with res_idx=i; res_last=1 at i=L-1.
  - COND_SUB, a_ge_m=1: res = low K bits of (aj - mj - b), borrow chain restarted at 0.
  - COND_SUB, a_ge_m=0: res = aj.
  - COPY: res = aj, a_ge_m forced 0, M RAM not read (addr_m held 0).
- Top-bit rule: the difference above word L-1 is discarded. Caller guarantees A < 2M.
- task_end timing: COND_SUB at T0+2L+3; COPY at T0+L+2.
- res_val is never asserted outside P2. res is held at its last value when res_val=0.

Optional Feature:
- Macro MM_IDDMM_CSUB_CLR_EN.
- Defined:
  - clra_mem=1 from accept through task_end.
  - In P2, clra_wren=1 in each res_val cycle with clra_addr=res_idx, zeroing A word i after it is read.
  - Clearing also occurs in COPY mode.
- Undefined: clra_mem, clra_wren and clra_addr are tied 0; the A RAM is untouched.

Decomposition:
- Package mm_iddmm_pkg holds:
  - FSM state enum (IDLE, P1, P2, DONE, WAIT_LOW).
  - Mode constants MODE_COND_SUB=0 and MODE_COPY=1.
  - Length-clamp function.
- One sub-module, mm_iddmm_borrow_sub: K-bit a - b - bin producing diff and bout. Shared by both passes; combinational with registered borrow in the parent.

Test Plan (K=128, N=4):
- len=1, an=0, a0=5, m0=3, COND_SUB -> one res_val with res=2, res_last=1, res_idx=0; a_ge_m=1; task_end at T0+5.
- len=1, an=0, a0=3, m0=5 -> res=3; a_ge_m=0.
- len=2, an=0, A words {w1=1, w0=0}, M {w1=0, w0=1} -> res0=2^128-1 (all ones), res1=0; a_ge_m=1 (borrow across words).
- len=2, an=1, A={0,0}, M={1,0} -> a_ge_m=1; res0=0, res1=all ones; top bit dropped.
- len=0 (treated as 4), COPY, random A -> res matches A words 0..3; addr_m stays 0; a_ge_m=0; task_end at T0+6. With MM_IDDMM_CSUB_CLR_EN, A RAM reads all zeros afterwards.
- rst_n pulsed low during P2 of a len=4 COND_SUB -> all outputs 0 immediately. A new request then completes correctly with 100 random A<2M vectors, checked against a golden big-number subtraction.
